// File: rtl/sensor_scanner_pkg.sv
// Shared types and sizes for the sensor_scanner slice (package sensor_pkg).
package sensor_pkg;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned CH_W           = 2;
  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    PRESENT = 3'd2,
    CAPTURE = 3'd3,
    NEXT    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/sensor_scanner_if.sv
// ADC request/ack and co-processor sample/change signals between scanner and its neighbours.
interface sensor_scanner_if #(
  parameter int unsigned DATA_W = sensor_pkg::DEFAULT_DATA_W
);
  import sensor_pkg::*;

  logic              adc_req;
  logic [CH_W-1:0]   adc_ch;
  logic              adc_ack;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] cp_data;
  logic [CH_W-1:0]   cp_sel;
  logic              cp_chg;
  logic [CH_W-1:0]   cp_chg_ch;

  modport master (
    output adc_req, adc_ch, cp_data, cp_sel,
    input  adc_ack, adc_data, cp_chg, cp_chg_ch
  );

  modport slave (
    input  adc_req, adc_ch, cp_data, cp_sel,
    output adc_ack, adc_data, cp_chg, cp_chg_ch
  );

endinterface

// File: rtl/sensor_scanner_flag_bank.sv
// Per-channel sticky flags: set pulses accumulate, write-1 clears, set wins over clear.
module sensor_flag_bank
  import sensor_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] set,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] flags
);

  always_ff @(posedge clk) begin
    if (!reset_n) flags <= '0;
    else          flags <= (flags & ~clr) | set;
  end

endmodule

// File: rtl/sensor_scanner.sv
// Round-robin sensor sequencer feeding the co-processor and collecting change/timeout flags.
// Define SENSOR_SCANNER_TIMEOUT_EN to enable the ADC ack timeout and err_mask.
module sensor_scanner
  import sensor_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  sensor_scanner_if.master  bus,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] chg_mask,
  output logic [NUM_CH-1:0] err_mask,
  output logic              irq,
  output logic              busy,
  output logic              scan_done
);

  localparam int unsigned     SETTLE_W = $clog2(SETTLE);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  if (SETTLE < 2 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("sensor_scanner: SETTLE must be >= 2 and TIMEOUT within 2..255");
  end

  scan_state_t         state, next_state;
  logic [CH_W-1:0]     ch;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DATA_W-1:0]   sample_c;
  logic                ack_c, settle_done_c, timeout_c;
  logic                adc_req_d, busy_d, scan_done_d;
  logic [NUM_CH-1:0]   chg_set, err_set;

  assign sample_c      = bus.adc_data;
  assign ack_c         = (state == REQ) && bus.adc_ack;
  assign settle_done_c = (settle_cnt == SETTLE_W'(SETTLE - 1));
  assign bus.adc_ch    = ch;

`ifdef SENSOR_SCANNER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  // Ack on the final REQ cycle still wins over the timeout.
  assign timeout_c = (state == REQ) && !bus.adc_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || state != REQ) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 8'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register and registered FSM outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      bus.adc_req <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      state       <= next_state;
      bus.adc_req <= adc_req_d;
      busy        <= busy_d;
      scan_done   <= scan_done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = REQ;
      REQ: begin
        if (ack_c)          next_state = PRESENT;
        else if (timeout_c) next_state = NEXT;
      end
      PRESENT: if (settle_done_c) next_state = CAPTURE;
      CAPTURE: next_state = NEXT;
      NEXT:    next_state = (ch != LAST_CH || en) ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state, plus flag-bank set pulses.
  always_comb begin
    adc_req_d   = 1'b0;
    busy_d      = 1'b0;
    scan_done_d = 1'b0;
    chg_set     = '0;
    err_set     = '0;
    adc_req_d   = (next_state == REQ);
    busy_d      = (next_state != IDLE);
    scan_done_d = (next_state == NEXT) && (ch == LAST_CH);
    if (state == CAPTURE && bus.cp_chg) chg_set[bus.cp_chg_ch] = 1'b1;
    if (timeout_c)                      err_set[ch]            = 1'b1;
  end

  // Channel pointer, settle counter and the sample held for the co-processor.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch          <= '0;
      settle_cnt  <= '0;
      bus.cp_data <= '0;
      bus.cp_sel  <= '0;
    end else begin
      if (ack_c) begin
        bus.cp_data <= sample_c;
        bus.cp_sel  <= ch;
      end
      if (state == PRESENT) settle_cnt <= settle_cnt + SETTLE_W'(1);
      else                  settle_cnt <= '0;
      if (state == NEXT)    ch <= ch + CH_W'(1);
    end
  end

  sensor_flag_bank u_chg_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (chg_set),
    .clr     (clr),
    .flags   (chg_mask)
  );

  sensor_flag_bank u_err_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (err_set),
    .clr     (clr),
    .flags   (err_mask)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
`ifdef SENSOR_SCANNER_TIMEOUT_EN
    else          irq <= (|chg_mask) | (|err_mask);
`else
    else          irq <= |chg_mask;
`endif
  end

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed bench for sensor_scanner with an ADC/co-processor responder and expected-sample queue.
module tb_sensor_scanner;
  import sensor_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [CH_W-1:0]   sel;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] chg_mask, err_mask;
  logic              irq, busy, scan_done;

  sensor_scanner_if #(.DATA_W(DATA_W)) bus ();

  sensor_scanner #(.DATA_W(DATA_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .bus       (bus),
    .clr       (clr),
    .chg_mask  (chg_mask),
    .err_mask  (err_mask),
    .irq       (irq),
    .busy      (busy),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int              passes = 0;
  int              fails  = 0;
  int              checks = 0;
  int              cyc    = 0;
  int              start;
  logic [CH_W-1:0] model_ch = '0;
  exp_t            exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_adc_req"}, 32'(bus.adc_req), 0);
    chk({tag, "_adc_ch"}, 32'(bus.adc_ch), 0);
    chk({tag, "_cp_data"}, 32'(bus.cp_data), 0);
    chk({tag, "_cp_sel"}, 32'(bus.cp_sel), 0);
    chk({tag, "_chg_mask"}, 32'(chg_mask), 0);
    chk({tag, "_err_mask"}, 32'(err_mask), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_scan_done"}, 32'(scan_done), 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.adc_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(bus.adc_req), 1);
  endtask

  // One channel with an immediate ack; optional stray flag in PRESENT and a flag/clr in CAPTURE.
  task automatic serve(input logic [DATA_W-1:0] data, input logic stray, input logic cap,
                       input logic [CH_W-1:0] cch, input logic [NUM_CH-1:0] cap_clr,
                       input logic exp_done);
    exp_t e;
    wait_req();
    chk("adc_ch", 32'(bus.adc_ch), 32'(model_ch));
    bus.adc_ack  = 1'b1;
    bus.adc_data = data;
    exp_q.push_back('{sel: model_ch, data: data});
    tick();
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    e = exp_q.pop_front();
    chk("cp_data", 32'(bus.cp_data), 32'(e.data));
    chk("cp_sel", 32'(bus.cp_sel), 32'(e.sel));
    if (stray) begin
      bus.cp_chg    = 1'b1;
      bus.cp_chg_ch = model_ch;
    end
    tick();
    bus.cp_chg   = 1'b0;
    bus.adc_ack  = 1'b1;
    bus.adc_data = 8'hEE;
    tick();
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    chk("cp_data_hold", 32'(bus.cp_data), 32'(e.data));
    if (cap) begin
      bus.cp_chg    = 1'b1;
      bus.cp_chg_ch = cch;
    end
    clr = cap_clr;
    tick();
    bus.cp_chg = 1'b0;
    clr        = '0;
    chk("scan_done", 32'(scan_done), 32'(exp_done));
    model_ch = model_ch + CH_W'(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    en            = 1'b0;
    clr           = '0;
    bus.adc_ack   = 1'b0;
    bus.adc_data  = '0;
    bus.cp_chg    = 1'b0;
    bus.cp_chg_ch = '0;
    repeat (3) tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_req", 32'(bus.adc_req), 0);

    // Basic round with immediate acks and no change flags.
    en = 1'b1;
    tick();
    start = cyc;
    chk("busy_on", 32'(busy), 1);
    for (int i = 0; i < 4; i++) serve(8'(8'h10 * (i + 1)), 1'b0, 1'b0, '0, '0, i == 3);
    chk("round_len", 32'(cyc - start), 19);
    chk("r1_chg_mask", 32'(chg_mask), 0);
    chk("r1_err_mask", 32'(err_mask), 0);
    chk("r1_irq", 32'(irq), 0);

    // Change capture on channel 2; stray flag on channel 0 outside CAPTURE.
    serve(8'h01, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("stray_chg", 32'(chg_mask), 0);
    serve(8'h02, 1'b0, 1'b0, '0, '0, 1'b0);
    serve(8'h03, 1'b0, 1'b1, 2'd2, '0, 1'b0);
    chk("chg_mask_ch2", 32'(chg_mask), 32'(4'b0100));
    chk("irq_lag", 32'(irq), 0);
    tick();
    chk("irq_set", 32'(irq), 1);
    serve(8'h04, 1'b0, 1'b0, '0, '0, 1'b1);

    // Set and clear of chg_mask[0] on the same edge, then clear alone.
    serve(8'h05, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    chk("set_wins", 32'(chg_mask), 32'(4'b0101));
    clr = 4'b0001;
    tick();
    clr = '0;
    chk("clr_bit0", 32'(chg_mask), 32'(4'b0100));

    // en dropped on channel 1: the round still completes, then IDLE.
    en = 1'b0;
    serve(8'h06, 1'b0, 1'b0, '0, '0, 1'b0);
    serve(8'h07, 1'b0, 1'b1, 2'd3, '0, 1'b0);
    serve(8'h08, 1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    chk("idle_after_drop", 32'(busy), 0);
    chk("req_after_drop", 32'(bus.adc_req), 0);
    repeat (3) tick();
    chk("stay_idle", 32'(busy), 0);
    chk("mask_kept", 32'(chg_mask), 32'(4'b1100));

    en = 1'b1;
    tick();
    serve(8'h55, 1'b0, 1'b0, '0, '0, 1'b0);
`ifdef SENSOR_SCANNER_TIMEOUT_EN
    begin
      int n = 0;
      tick();
      chk("tmo_ch", 32'(bus.adc_ch), 1);
      while (bus.adc_req && n < 40) begin
        n++;
        tick();
      end
      chk("tmo_req_len", 32'(n), TIMEOUT);
      chk("tmo_err_mask", 32'(err_mask), 32'(4'b0010));
      chk("tmo_cp_data", 32'(bus.cp_data), 32'h55);
      chk("tmo_cp_sel", 32'(bus.cp_sel), 0);
      tick();
      chk("tmo_next_ch", 32'(bus.adc_ch), 2);
      chk("tmo_next_req", 32'(bus.adc_req), 1);
      model_ch = 2'd2;
    end
`else
    serve(8'h66, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("no_err_mask", 32'(err_mask), 0);
`endif
    serve(8'h77, 1'b0, 1'b0, '0, '0, 1'b0);
    serve(8'h88, 1'b0, 1'b0, '0, '0, 1'b1);

    // Reset while requesting channel 0 with an ack on the same edge.
    tick();
    chk("pre_rst_req", 32'(bus.adc_req), 1);
    chk("pre_rst_irq", 32'(irq), 1);
    bus.adc_ack  = 1'b1;
    bus.adc_data = 8'hAA;
    reset_n      = 1'b0;
    tick();
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    chk_zero("midrst");
    reset_n = 1'b1;
    en      = 1'b0;
    tick();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
